mr_wb_arb: RTL and testbench
============================

# mr_wb_arb

Writeback arbiter that shares the decode stage's single register-file write port (`wb_valid`/`wb_reg`/`wb_val`) between two result producers: the execute path (ALU results, JAL/JALR link values) and the memory path (load data). It grants in program order using a sequence tag assigned at issue, so multiple in-flight writes to the same register retire in order and the decode stage's pending-write counters stay consistent. The write port output is registered and is the only writer of the decode stage's write-back inputs.

## Interface
- `XLEN`, 32, data width.
- `REGSEL_BITS`, 5, destination register index width.
- `SEQ_BITS`, 4, program-order tag width; at most 2^(SEQ_BITS-1) results in flight.
- `clk  in  1  clock; all logic on rising edge`
- `rst  in  1  synchronous, active-high reset`
- `ex_valid  in  1  execute result available`
- `ex_ready  out  1  execute result consumed this cycle`
- `ex_reg  in  REGSEL_BITS  destination register`
- `ex_val  in  XLEN  result value`
- `ex_seq  in  SEQ_BITS  issue-order tag`
- `mem_valid, mem_ready, mem_reg, mem_val, mem_seq`: same as the `ex_*` ports, for load results.
- `wb_valid  out  1  register-file write strobe to decode`
- `wb_reg  out  REGSEL_BITS  register written`
- `wb_val  out  XLEN  value written`
- `retire_count  out  32  number of granted results, including x0`

## Operation
- A source handshake completes when `*_valid & *_ready` are both high. The source holds `reg`/`val`/`seq` stable while valid and not ready.
- Grant rule, per cycle, with `rst` low:
  - Neither valid: no grant.
  - Exactly one valid: grant it.
  - Both valid: grant the older source.
  - a is older than b iff bit `SEQ_BITS-1` of `(a_seq - b_seq) mod 2^SEQ_BITS` is 1.
  - Equal tags with both valid is illegal: assertion fires, and `mem` is granted.
- `ex_ready` and `mem_ready` are combinational from the grant: at most one is high per cycle, and both are 0 while `rst` is high.
- A grant with `reg != 0` registers `wb_valid=1`, `wb_reg=reg`, `wb_val=val` on the next edge.
- A grant with `reg == 0` is consumed and counted, but `wb_valid` stays 0 and `wb_reg`/`wb_val` hold their previous values.
- With no grant: `wb_valid=0` and `wb_reg`/`wb_val` hold.
- `retire_count` increments by 1 per grant and wraps modulo 2^32.
- Reset values: `wb_valid=0`, `wb_reg=0`, `wb_val=0`, `retire_count=0`.
- Reset mid-operation: pending source requests are not granted during reset and are not retained. Sources re-present after reset if still valid.
- The decode stage accepts every write, so there is no back-pressure on the `wb_*` output.

## Timing
- Latency: handshake in cycle N gives `wb_valid` in cycle N+1, for one cycle.
- Throughput: one grant per cycle. The losing source waits at least one cycle.
- No combinational path from any `*_val` to `wb_*`.
- The only combinational paths are valid/seq to ready.
- Back-to-back grants to the same register produce consecutive `wb_valid` cycles in tag order.

## Structure
- Shared package `mr_pkg` holds:
  - the `SEQ_BITS` default;
  - a `wb_req_t` struct {reg, val, seq};
  - an `is_older(a, b)` function for modular tag comparison.
- The package is also used by the decode-stage tag generator.
- One sub-module, `mr_wb_grant`, is natural: the combinational two-way age compare and grant logic.
- The top level contains the output register and `retire_count`.

## Test plan
- Reset: hold `rst` 3 cycles with both valid -> both readies 0, `wb_valid=0`, `retire_count=0`. Release -> older source granted in the first cycle.
- Single source: ex {reg=5, val=0x1234, seq=2} -> `ex_ready` same cycle; next cycle `wb_valid=1`, `wb_reg=5`, `wb_val=0x1234`; `retire_count=1`.
- Ordering: mem {reg=7, seq=3} and ex {reg=7, seq=4} simultaneously -> mem granted first, ex the next cycle; `wb_val` sequence mem then ex; `retire_count=2`.
- Wrap: ex seq=15, mem seq=0 (SEQ_BITS=4) -> ex is older, so ex is granted first.
- x0 drop: mem {reg=0, val=0xFFFF} -> `mem_ready=1`, `wb_valid` stays 0, `retire_count` increments.
- Reset mid-stream: assert `rst` while mem is waiting behind ex -> no grant and `wb_valid=0` next cycle; after release mem is granted normally.

Source files
------------

// File: rtl/mr_pkg.sv
// Shared writeback definitions: default widths, the writeback request record and
// the modular age compare used by both the tag generator and the writeback arbiter.
package mr_pkg;

    localparam int DEFAULT_XLEN        = 32;
    localparam int DEFAULT_REGSEL_BITS = 5;
    localparam int DEFAULT_SEQ_BITS    = 4;

    typedef struct packed {
        logic [DEFAULT_REGSEL_BITS-1:0] regsel;
        logic [DEFAULT_XLEN-1:0]        val;
        logic [DEFAULT_SEQ_BITS-1:0]    seq;
    } wb_req_t;

    // Tags wrap, so a is older than b when the top tag bit of (a - b) mod 2^bits is set.
    function automatic logic is_older(input logic [31:0] a, input logic [31:0] b, input int bits);
        logic [31:0] mask;
        logic [31:0] diff;
        mask = (32'd1 << bits) - 32'd1;
        diff = (a - b) & mask;
        return diff >= (32'd1 << (bits - 1));
    endfunction

endpackage

// File: rtl/mr_wb_grant.sv
// Combinational two-way grant between the execute and memory result paths,
// favouring whichever result was issued first.
module mr_wb_grant
    import mr_pkg::*;
#(
    parameter int SEQ_BITS = DEFAULT_SEQ_BITS
) (
    input  logic                rst,
    input  logic                ex_valid,
    input  logic [SEQ_BITS-1:0] ex_seq,
    input  logic                mem_valid,
    input  logic [SEQ_BITS-1:0] mem_seq,
    output logic                ex_grant,
    output logic                mem_grant
);

    logic ex_first;

    // Equal tags never compare as older, so that illegal case falls through to mem.
    always_comb begin
        ex_first  = is_older(32'(ex_seq), 32'(mem_seq), SEQ_BITS);
        ex_grant  = 1'b0;
        mem_grant = 1'b0;
        if (!rst) begin
            if (ex_valid && (!mem_valid || ex_first)) begin
                ex_grant = 1'b1;
            end else if (mem_valid) begin
                mem_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mr_wb_arb.sv
// Writeback arbiter: shares the single register-file write port between execute and
// load results in issue order, with a registered write port and a retire counter.
module mr_wb_arb
    import mr_pkg::*;
#(
    parameter int XLEN        = DEFAULT_XLEN,
    parameter int REGSEL_BITS = DEFAULT_REGSEL_BITS,
    parameter int SEQ_BITS    = DEFAULT_SEQ_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_valid,
    output logic                   ex_ready,
    input  logic [REGSEL_BITS-1:0] ex_reg,
    input  logic [XLEN-1:0]        ex_val,
    input  logic [SEQ_BITS-1:0]    ex_seq,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [REGSEL_BITS-1:0] mem_reg,
    input  logic [XLEN-1:0]        mem_val,
    input  logic [SEQ_BITS-1:0]    mem_seq,
    output logic                   wb_valid,
    output logic [REGSEL_BITS-1:0] wb_reg,
    output logic [XLEN-1:0]        wb_val,
    output logic [31:0]            retire_count
);

    logic                   ex_grant;
    logic                   mem_grant;
    logic                   any_grant;
    logic                   writes_reg;
    logic [REGSEL_BITS-1:0] sel_reg;
    logic [XLEN-1:0]        sel_val;

    mr_wb_grant #(
        .SEQ_BITS (SEQ_BITS)
    ) u_grant (
        .rst       (rst),
        .ex_valid  (ex_valid),
        .ex_seq    (ex_seq),
        .mem_valid (mem_valid),
        .mem_seq   (mem_seq),
        .ex_grant  (ex_grant),
        .mem_grant (mem_grant)
    );

    assign ex_ready  = ex_grant;
    assign mem_ready = mem_grant;

    always_comb begin
        any_grant  = ex_grant | mem_grant;
        sel_reg    = mem_grant ? mem_reg : ex_reg;
        sel_val    = mem_grant ? mem_val : ex_val;
        writes_reg = any_grant && (sel_reg != '0);
    end

    // Writes to x0 retire and count but never strobe the register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            wb_reg       <= '0;
            wb_val       <= '0;
            retire_count <= '0;
        end else begin
            wb_valid <= writes_reg;
            if (writes_reg) begin
                wb_reg <= sel_reg;
                wb_val <= sel_val;
            end
            if (any_grant) begin
                retire_count <= retire_count + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && ex_valid && mem_valid) begin
            assert (ex_seq != mem_seq)
                else $error("mr_wb_arb: execute and memory results carry the same tag");
        end
    end

endmodule

// File: tb/tb_mr_wb_arb.sv
// Self-checking bench for mr_wb_arb: directed scenarios plus a randomized
// in-order result stream checked against a program-index reference model.
module tb_mr_wb_arb;
    import mr_pkg::*;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_reg;
    logic [31:0] ex_val;
    logic [3:0]  ex_seq;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_reg;
    logic [31:0] mem_val;
    logic [3:0]  mem_seq;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_val;
    logic [31:0] retire_count;

    int tests;
    int failures;
    int exp_retire;

    mr_wb_arb dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_reg       (ex_reg),
        .ex_val       (ex_val),
        .ex_seq       (ex_seq),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_reg      (mem_reg),
        .mem_val      (mem_val),
        .mem_seq      (mem_seq),
        .wb_valid     (wb_valid),
        .wb_reg       (wb_reg),
        .wb_val       (wb_val),
        .retire_count (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_ex(input logic v, input logic [4:0] r, input logic [31:0] d, input logic [3:0] s);
        ex_valid = v; ex_reg = r; ex_val = d; ex_seq = s;
    endtask

    task automatic set_mem(input logic v, input logic [4:0] r, input logic [31:0] d, input logic [3:0] s);
        mem_valid = v; mem_reg = r; mem_val = d; mem_seq = s;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        set_ex(1'b1, 5'd1, 32'hAAAA_0001, 4'd2);
        set_mem(1'b1, 5'd2, 32'hBBBB_0002, 4'd3);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            tests++;
            if ({ex_ready, mem_ready} !== 2'b00) begin
                failures++;
                $display("[TB] FAIL reset_ready: got %b, want 00", {ex_ready, mem_ready});
            end
            tests++;
            if (wb_valid !== 1'b0 || retire_count !== 32'd0) begin
                failures++;
                $display("[TB] FAIL reset_state: wb_valid=%b retire=%0d, want 0/0", wb_valid, retire_count);
            end
        end
        rst = 1'b0;
        exp_retire = 0;
        #1;
        tests++;
        if ({ex_ready, mem_ready} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL reset_release_grant: got %b, want 10", {ex_ready, mem_ready});
        end
        @(negedge clk);
        exp_retire++;
        ex_valid = 1'b0;
        tests++;
        if (wb_valid !== 1'b1 || wb_reg !== 5'd1 || wb_val !== 32'hAAAA_0001 || retire_count !== 32'd1) begin
            failures++;
            $display("[TB] FAIL reset_release_wb: got %b/%0d/%h/%0d, want 1/1/aaaa0001/1",
                     wb_valid, wb_reg, wb_val, retire_count);
        end
        #1;
        tests++;
        if (mem_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_release_mem: mem_ready=%b, want 1", mem_ready);
        end
        @(negedge clk);
        exp_retire++;
        mem_valid = 1'b0;
        tests++;
        if (wb_valid !== 1'b1 || wb_reg !== 5'd2 || wb_val !== 32'hBBBB_0002 || retire_count !== 32'd2) begin
            failures++;
            $display("[TB] FAIL reset_release_wb2: got %b/%0d/%h/%0d, want 1/2/bbbb0002/2",
                     wb_valid, wb_reg, wb_val, retire_count);
        end
        @(negedge clk);
        tests++;
        if (wb_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_wb_valid: got %b, want 0", wb_valid);
        end
    endtask

    task automatic test_single();
        set_ex(1'b1, 5'd5, 32'h0000_1234, 4'd2);
        #1;
        tests++;
        if ({ex_ready, mem_ready} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL single_ready: got %b, want 10", {ex_ready, mem_ready});
        end
        @(negedge clk);
        exp_retire++;
        ex_valid = 1'b0;
        tests++;
        if (wb_valid !== 1'b1 || wb_reg !== 5'd5 || wb_val !== 32'h1234 || retire_count !== 32'(exp_retire)) begin
            failures++;
            $display("[TB] FAIL single_wb: got %b/%0d/%h/%0d, want 1/5/1234/%0d",
                     wb_valid, wb_reg, wb_val, retire_count, exp_retire);
        end
    endtask

    task automatic test_ordering();
        int start;
        start = exp_retire;
        set_mem(1'b1, 5'd7, 32'h0000_0070, 4'd3);
        set_ex(1'b1, 5'd7, 32'h0000_0071, 4'd4);
        #1;
        tests++;
        if ({ex_ready, mem_ready} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL order_first: got %b, want 01", {ex_ready, mem_ready});
        end
        @(negedge clk);
        exp_retire++;
        mem_valid = 1'b0;
        tests++;
        if (wb_valid !== 1'b1 || wb_reg !== 5'd7 || wb_val !== 32'h70) begin
            failures++;
            $display("[TB] FAIL order_wb_mem: got %b/%0d/%h, want 1/7/70", wb_valid, wb_reg, wb_val);
        end
        #1;
        tests++;
        if ({ex_ready, mem_ready} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL order_second: got %b, want 10", {ex_ready, mem_ready});
        end
        @(negedge clk);
        exp_retire++;
        ex_valid = 1'b0;
        tests++;
        if (wb_valid !== 1'b1 || wb_reg !== 5'd7 || wb_val !== 32'h71 || retire_count !== 32'(start + 2)) begin
            failures++;
            $display("[TB] FAIL order_wb_ex: got %b/%0d/%h/%0d, want 1/7/71/%0d",
                     wb_valid, wb_reg, wb_val, retire_count, start + 2);
        end
    endtask

    task automatic test_wrap();
        set_ex(1'b1, 5'd3, 32'h0000_0015, 4'd15);
        set_mem(1'b1, 5'd4, 32'h0000_0040, 4'd0);
        #1;
        tests++;
        if ({ex_ready, mem_ready} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL wrap_grant: got %b, want 10", {ex_ready, mem_ready});
        end
        @(negedge clk);
        exp_retire++;
        ex_valid = 1'b0;
        tests++;
        if (wb_reg !== 5'd3 || wb_val !== 32'h15) begin
            failures++;
            $display("[TB] FAIL wrap_wb_ex: got %0d/%h, want 3/15", wb_reg, wb_val);
        end
        @(negedge clk);
        exp_retire++;
        mem_valid = 1'b0;
        tests++;
        if (wb_valid !== 1'b1 || wb_reg !== 5'd4 || wb_val !== 32'h40) begin
            failures++;
            $display("[TB] FAIL wrap_wb_mem: got %b/%0d/%h, want 1/4/40", wb_valid, wb_reg, wb_val);
        end
    endtask

    task automatic test_x0_drop();
        set_mem(1'b1, 5'd0, 32'h0000_FFFF, 4'd5);
        #1;
        tests++;
        if (mem_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL x0_ready: mem_ready=%b, want 1", mem_ready);
        end
        @(negedge clk);
        exp_retire++;
        mem_valid = 1'b0;
        tests++;
        if (wb_valid !== 1'b0 || wb_reg !== 5'd4 || wb_val !== 32'h40 || retire_count !== 32'(exp_retire)) begin
            failures++;
            $display("[TB] FAIL x0_drop: got %b/%0d/%h/%0d, want 0/4/40/%0d",
                     wb_valid, wb_reg, wb_val, retire_count, exp_retire);
        end
    endtask

    task automatic test_reset_midstream();
        set_ex(1'b1, 5'd9, 32'h0000_0090, 4'd6);
        set_mem(1'b1, 5'd10, 32'h0000_00A0, 4'd7);
        @(negedge clk);
        ex_valid = 1'b0;
        rst = 1'b1;
        tests++;
        if (wb_reg !== 5'd9 || wb_val !== 32'h90) begin
            failures++;
            $display("[TB] FAIL mid_ex_wb: got %0d/%h, want 9/90", wb_reg, wb_val);
        end
        #1;
        tests++;
        if (mem_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_reset_ready: mem_ready=%b, want 0", mem_ready);
        end
        @(negedge clk);
        tests++;
        if (wb_valid !== 1'b0 || wb_reg !== 5'd0 || wb_val !== 32'd0 || retire_count !== 32'd0) begin
            failures++;
            $display("[TB] FAIL mid_reset_state: got %b/%0d/%h/%0d, want 0/0/0/0",
                     wb_valid, wb_reg, wb_val, retire_count);
        end
        rst = 1'b0;
        exp_retire = 0;
        #1;
        tests++;
        if ({ex_ready, mem_ready} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL mid_after_ready: got %b, want 01", {ex_ready, mem_ready});
        end
        @(negedge clk);
        exp_retire++;
        mem_valid = 1'b0;
        tests++;
        if (wb_valid !== 1'b1 || wb_reg !== 5'd10 || wb_val !== 32'hA0 || retire_count !== 32'd1) begin
            failures++;
            $display("[TB] FAIL mid_after_wb: got %b/%0d/%h/%0d, want 1/10/a0/1",
                     wb_valid, wb_reg, wb_val, retire_count);
        end
    endtask

    // Results are numbered in program order; the oldest presented one must win.
    task automatic test_random();
        wb_req_t     exq[$];
        wb_req_t     memq[$];
        int          exi[$];
        int          memi[$];
        wb_req_t     item;
        int          next_idx;
        int          oldest;
        logic        want_ex;
        logic        want_mem;
        logic        clr_ex;
        logic        clr_mem;
        logic        exp_v;
        logic [4:0]  exp_r;
        logic [31:0] exp_d;

        @(negedge clk);
        rst = 1'b1;
        ex_valid = 1'b0;
        mem_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        next_idx = 0;
        exp_retire = 0;
        exp_v = 1'b0;
        exp_r = '0;
        exp_d = '0;
        clr_ex = 1'b0;
        clr_mem = 1'b0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc != 0) @(negedge clk);
            tests++;
            if (wb_valid !== exp_v || wb_reg !== exp_r || wb_val !== exp_d || retire_count !== 32'(exp_retire)) begin
                failures++;
                $display("[TB] FAIL random_wb cycle %0d: got %b/%0d/%h/%0d, want %b/%0d/%h/%0d",
                         cyc, wb_valid, wb_reg, wb_val, retire_count, exp_v, exp_r, exp_d, exp_retire);
            end
            if (clr_ex) ex_valid = 1'b0;
            if (clr_mem) mem_valid = 1'b0;

            oldest = next_idx;
            if (exi.size() > 0 && exi[0] < oldest) oldest = exi[0];
            if (memi.size() > 0 && memi[0] < oldest) oldest = memi[0];
            if (next_idx - oldest < 8 && $urandom_range(0, 2) != 0) begin
                item.regsel = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                item.val    = $urandom;
                item.seq    = 4'(next_idx % 16);
                if ($urandom_range(0, 1) == 0) begin
                    exq.push_back(item);
                    exi.push_back(next_idx);
                end else begin
                    memq.push_back(item);
                    memi.push_back(next_idx);
                end
                next_idx++;
            end

            if (!ex_valid && exq.size() > 0 && $urandom_range(0, 3) != 0)
                set_ex(1'b1, exq[0].regsel, exq[0].val, exq[0].seq);
            if (!mem_valid && memq.size() > 0 && $urandom_range(0, 3) != 0)
                set_mem(1'b1, memq[0].regsel, memq[0].val, memq[0].seq);

            want_ex  = ex_valid && (!mem_valid || exi[0] < memi[0]);
            want_mem = mem_valid && !want_ex;
            #1;
            tests++;
            if (ex_ready !== want_ex || mem_ready !== want_mem) begin
                failures++;
                $display("[TB] FAIL random_ready cycle %0d: got %b%b, want %b%b",
                         cyc, ex_ready, mem_ready, want_ex, want_mem);
            end

            clr_ex  = want_ex;
            clr_mem = want_mem;
            exp_v   = 1'b0;
            if (want_ex || want_mem) begin
                if (want_ex) begin
                    item = exq.pop_front();
                    void'(exi.pop_front());
                end else begin
                    item = memq.pop_front();
                    void'(memi.pop_front());
                end
                exp_retire++;
                if (item.regsel != 5'd0) begin
                    exp_v = 1'b1;
                    exp_r = item.regsel;
                    exp_d = item.val;
                end
            end
        end
        @(negedge clk);
        tests++;
        if (wb_valid !== exp_v || wb_reg !== exp_r || wb_val !== exp_d || retire_count !== 32'(exp_retire)) begin
            failures++;
            $display("[TB] FAIL random_final: got %b/%0d/%h/%0d, want %b/%0d/%h/%0d",
                     wb_valid, wb_reg, wb_val, retire_count, exp_v, exp_r, exp_d, exp_retire);
        end
        ex_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    initial begin
        tests = 0;
        failures = 0;
        exp_retire = 0;
        rst = 1'b1;
        set_ex(1'b0, '0, '0, '0);
        set_mem(1'b0, '0, '0, '0);
        test_reset();
        test_single();
        test_ordering();
        test_wrap();
        test_x0_drop();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
